// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell built from two half adders.
// The sum is formed LSB-first, one bit per clock, under a start/done handshake.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSTART,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [WIDTH-1:0] oSUM,
    output logic             oCARRY
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic ha0_s, ha0_c, bit_s, ha1_c, carry_nxt;

    half_adder u_ha0 (
        .a (a_q[0]),
        .b (b_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .a (ha0_s),
        .b (carry_q),
        .s (bit_s),
        .c (ha1_c)
    );

    assign carry_nxt = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (iSTART) begin
                    a_d     = iA;
                    b_d     = iB;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + 1'b1;
                // Last bit: publish the completed word, not the stale register.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign oBUSY  = (state_q == SHIFT);
    assign oDONE  = (state_q == DONE);
    assign oSUM   = sum_q;
    assign oCARRY = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8 and WIDTH=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, carry2;
    logic [1:0] sum2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .iSTART (start8),
        .iA     (a8),
        .iB     (b8),
        .oBUSY  (busy8),
        .oDONE  (done8),
        .oSUM   (sum8),
        .oCARRY (carry8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .iSTART (start2),
        .iA     (a2),
        .iB     (b2),
        .oBUSY  (busy2),
        .oDONE  (done2),
        .oSUM   (sum2),
        .oCARRY (carry2)
    );

    // Stimulus only: pulses start and reports busy count / done latency.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int busy_n, output int lat);
        busy_n = 0;
        lat = -1;
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (busy8) busy_n++;
            if (done8) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy8, done8, carry8, sum8} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {busy8, done8, carry8, sum8});
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy8, done8, sum8} !== 10'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected 0",
                     {busy8, done8, sum8});
        end
    endtask

    task automatic test_latency();
        int bn, lat;
        run8(8'h00, 8'h00, bn, lat);
        checks++;
        if (bn !== 8) begin
            failures++;
            $display("FAIL busy_cycles: got %0d expected 8", bn);
        end
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL done_latency: got %0d expected 9", lat);
        end
        checks++;
        if ({carry8, sum8} !== 9'h000) begin
            failures++;
            $display("FAIL sum_0_0: got %h expected 000", {carry8, sum8});
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle: got %b expected 0", done8);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'hFF};
        logic [7:0] vb [3] = '{8'h01, 8'h01, 8'hFF};
        logic [8:0] ve [3] = '{9'h010, 9'h100, 9'h1FE};
        int bn, lat;
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], bn, lat);
            checks++;
            if (lat !== 9 || {carry8, sum8} !== ve[i]) begin
                failures++;
                $display("FAIL add_%h_%h: got %h lat %0d expected %h lat 9",
                         va[i], vb[i], {carry8, sum8}, lat, ve[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        bit early = 0;
        a8 = 8'h12;
        b8 = 8'h34;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            if (n == 3) begin
                a8 = 8'h55;
                b8 = 8'h66;
                start8 = 1'b1;
            end
            if (n == 4) start8 = 1'b0;
            if (done8) begin
                dones++;
                checks++;
                if ({carry8, sum8} !== 9'h046) begin
                    failures++;
                    $display("FAIL captured_operands: got %h expected 046",
                             {carry8, sum8});
                end
            end else if (dones == 0 && sum8 !== 8'hFE) begin
                early = 1;
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL start_ignored: got %0d dones expected 1", dones);
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL sum_hold: got changed oSUM expected FE held");
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int last = 0;
        bit prev = 0;
        bit bad_gap = 0, wide = 0, bad_sum = 0;
        a8 = 8'h01;
        b8 = 8'h02;
        start8 = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 50; n++) begin
            if (done8) begin
                if (prev) wide = 1;
                if (cnt == 0 && n != 9) bad_gap = 1;
                if (cnt > 0 && n - last != 10) bad_gap = 1;
                if ({carry8, sum8} !== 9'h003) bad_sum = 1;
                cnt++;
                last = n;
                if (cnt == 4) begin
                    start8 = 1'b0;
                    break;
                end
            end
            prev = done8;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (cnt !== 4 || bad_gap) begin
            failures++;
            $display("FAIL repeat_period: got %0d dones gap_err %0b expected 4 every 10",
                     cnt, bad_gap);
        end
        checks++;
        if (wide || done8 !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: got wide %0b expected single cycle", wide);
        end
        checks++;
        if (bad_sum) begin
            failures++;
            $display("FAIL repeat_sum: got wrong sum expected 003");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int bn, lat;
        bit saw_done = 0;
        a8 = 8'h12;
        b8 = 8'h34;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_shift: got %b expected 1", busy8);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, carry8, sum8} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset: got %b expected 0",
                     {busy8, done8, carry8, sum8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8 || busy8) saw_done = 1;
        end
        checks++;
        if (saw_done || {carry8, sum8} !== 9'h000) begin
            failures++;
            $display("FAIL abort: got activity %0b out %h expected none 000",
                     saw_done, {carry8, sum8});
        end
        run8(8'h80, 8'h80, bn, lat);
        checks++;
        if (lat !== 9 || {carry8, sum8} !== 9'h100) begin
            failures++;
            $display("FAIL add_after_abort: got %h lat %0d expected 100 lat 9",
                     {carry8, sum8}, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_width2();
        int lat;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a2 = 2'(i);
                b2 = 2'(j);
                start2 = 1'b1;
                @(negedge clk);
                start2 = 1'b0;
                lat = -1;
                for (int n = 1; n <= 10; n++) begin
                    if (done2) begin
                        lat = n;
                        break;
                    end
                    @(negedge clk);
                end
                checks++;
                if (lat !== 3 || {carry2, sum2} !== 3'(i + j)) begin
                    failures++;
                    $display("FAIL w2_%0d_%0d: got %0d lat %0d expected %0d lat 3",
                             i, j, {carry2, sum2}, lat, i + j);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_width2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
